// File: rtl/multicycle_seq.sv
// Multicycle CPU control sequencer: program-load window, then FETCH/DECODE/EXEC/MEM/WB until a halt.
// Define MULTICYCLE_SEQ_PERF_EN to add the retired-instruction and memory-stall counters.
module multicycle_seq #(
   parameter int LOAD_CYCLES = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [5:0]  op,
   input  logic        halt_instr,
   input  logic        zero,
   input  logic        dmem_ready,
   output logic        load_en,
   output logic        ir_en,
   output logic        alu_en,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        reg_write,
   output logic        pc_en,
   output logic        pc_sel,
   output logic [2:0]  state,
   output logic        halted,
   output logic        timeout_err
`ifdef MULTICYCLE_SEQ_PERF_EN
   ,
   output logic [31:0] retired,
   output logic [31:0] stall_cycles
`endif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      FETCH  = 3'd2,
      DECODE = 3'd3,
      EXEC   = 3'd4,
      MEM    = 3'd5,
      WB     = 3'd6,
      HALT   = 3'd7
   } state_t;

   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [9:0] LOAD_LAST = 10'(LOAD_CYCLES - 1);
   localparam logic [7:0] MEM_LAST  = 8'(MEM_TIMEOUT - 1);

   state_t     state_reg, state_next;
   logic [9:0] load_cnt_reg, load_cnt_next;
   logic [7:0] wait_cnt_reg, wait_cnt_next;
   logic       timeout_err_reg, timeout_err_next;
   logic       is_lw, is_sw, is_beq;

   assign is_lw  = (op == OP_LW);
   assign is_sw  = (op == OP_SW);
   assign is_beq = (op == OP_BEQ);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         load_cnt_reg    <= '0;
         wait_cnt_reg    <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         load_cnt_reg    <= load_cnt_next;
         wait_cnt_reg    <= wait_cnt_next;
         timeout_err_reg <= timeout_err_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      load_cnt_next    = load_cnt_reg;
      wait_cnt_next    = wait_cnt_reg;
      timeout_err_next = timeout_err_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next    = LOAD;
               load_cnt_next = '0;
            end
         end
         LOAD: begin
            if (load_cnt_reg == LOAD_LAST) begin
               state_next = FETCH;
            end else begin
               load_cnt_next = load_cnt_reg + 10'd1;
            end
         end
         FETCH:  state_next = DECODE;
         DECODE: state_next = halt_instr ? HALT : EXEC;
         EXEC: begin
            if (is_lw || is_sw) begin
               state_next    = MEM;
               wait_cnt_next = '0;
            end else if (is_beq) begin
               state_next = FETCH;
            end else begin
               state_next = WB;
            end
         end
         MEM: begin
            // A ready strobe in the last allowed cycle still wins over the timeout.
            if (dmem_ready) begin
               state_next = is_sw ? FETCH : WB;
            end else if (wait_cnt_reg == MEM_LAST) begin
               state_next       = HALT;
               timeout_err_next = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt_reg + 8'd1;
            end
         end
         WB: state_next = FETCH;
         HALT: begin
            if (start) begin
               state_next       = LOAD;
               load_cnt_next    = '0;
               timeout_err_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Strobes follow the state register; op/zero come from the held instruction register,
   // and the sw PC update is qualified by the completing ready so it fires exactly once.
   always_comb begin
      load_en   = 1'b0;
      ir_en     = 1'b0;
      alu_en    = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_write = 1'b0;
      pc_en     = 1'b0;
      pc_sel    = 1'b0;
      case (state_reg)
         LOAD:  load_en = 1'b1;
         FETCH: ir_en = 1'b1;
         EXEC: begin
            alu_en = 1'b1;
            if (is_beq) begin
               pc_en  = 1'b1;
               pc_sel = zero;
            end
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_sw;
            if (is_sw && dmem_ready) begin
               pc_en = 1'b1;
            end
         end
         WB: begin
            reg_write = 1'b1;
            pc_en     = 1'b1;
         end
         default: ;
      endcase
   end

   assign state       = state_reg;
   assign halted      = (state_reg == HALT);
   assign timeout_err = timeout_err_reg;

`ifdef MULTICYCLE_SEQ_PERF_EN
   logic [31:0] retired_reg;
   logic [31:0] stall_cycles_reg;
   logic        load_entry;

   assign load_entry = ((state_reg == IDLE) || (state_reg == HALT)) && start;

   always_ff @(posedge clk) begin
      if (!rst_n || load_entry) begin
         retired_reg      <= '0;
         stall_cycles_reg <= '0;
      end else begin
         if (pc_en) begin
            retired_reg <= retired_reg + 32'd1;
         end
         if ((state_reg == MEM) && !dmem_ready) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
         end
      end
   end

   assign retired      = retired_reg;
   assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: doc/multicycle_seq.md
MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

Interface
REQ-001 SHALL have parameter LOAD_CYCLES, default 32: number of cycles in the program-load window (range 1..1023).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15: maximum cycles spent in MEM waiting for dmem_ready (range 1..255).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1: begin load-and-run; sampled only in IDLE and HALT.
REQ-006 SHALL have port op, input, 6: opcode of the current instruction (instruction[31:26]).
REQ-007 SHALL have port halt_instr, input, 1: current instruction is all ones.
REQ-008 SHALL have port zero, input, 1: ALU zero flag.
REQ-009 SHALL have port dmem_ready, input, 1: data-memory completion strobe.
REQ-010 SHALL have port load_en, output, 1: instruction and data memories accept loader writes.
REQ-011 SHALL have ports ir_en, alu_en, dmem_req, dmem_we, reg_write, pc_en and pc_sel, each output, 1: datapath strobes; pc_sel=1 selects the branch target.
REQ-012 SHALL have port state, output, 3: current state encoding.
REQ-013 SHALL have ports halted and timeout_err, each output, 1: status flags.

Function
REQ-014 SHALL use states IDLE=0, LOAD=1, FETCH=2, DECODE=3, EXEC=4, MEM=5, WB=6, HALT=7; strobes SHALL be decoded from the state register only (Moore).
REQ-015 IDLE: start=1 -> LOAD with load counter cleared; otherwise stay in IDLE.
REQ-016 LOAD: load_en=1 for exactly LOAD_CYCLES cycles, then -> FETCH.
REQ-017 FETCH: ir_en=1 for one cycle, then -> DECODE.
REQ-018 DECODE: halt_instr=1 -> HALT; otherwise -> EXEC.
REQ-019 EXEC: alu_en=1; op=6'h23 (lw) or 6'h2B (sw) -> MEM; op=6'h04 (beq) -> FETCH with pc_en=1 and pc_sel=zero; any other op -> WB.
REQ-020 MEM: dmem_req=1 and dmem_we=(op==6'h2B), both held until dmem_ready; when dmem_ready=1, sw -> FETCH with pc_en=1, and lw -> WB.
REQ-021 MEM timeout: if dmem_ready is still low after MEM_TIMEOUT cycles in MEM -> HALT with timeout_err set; dmem_ready arriving in the final allowed cycle SHALL complete the access normally.
REQ-022 WB: reg_write=1 and pc_en=1 for one cycle, pc_sel=0, then -> FETCH.
REQ-023 HALT: halted=1, all strobes 0; start=1 -> LOAD, clears timeout_err and restarts the load counter.
REQ-024 Each instruction SHALL assert pc_en exactly once; cycles per instruction: R-type 4, beq 3, sw 4+wait, lw 5+wait.
REQ-025 Start asserted outside IDLE/HALT SHALL be ignored.
REQ-026 dmem_ready outside MEM SHALL be ignored.
REQ-027 Undefined state encodings are unreachable; any such state SHALL -> IDLE on the next cycle.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, clear the load, wait and perf counters, and clear timeout_err, regardless of the current state, including mid-LOAD or mid-MEM.
REQ-029 During and after reset, all strobes, halted and timeout_err SHALL be 0 and state SHALL be 0.

Configuration
REQ-030 Macro MULTICYCLE_SEQ_PERF_EN defined: add outputs retired (32 bits, increments on every pc_en) and stall_cycles (32 bits, increments on every MEM cycle with dmem_ready=0), both cleared by reset and on the LOAD entry; macro undefined: neither port nor counter exists and behaviour is otherwise identical.

Verification
REQ-031 Reset release, start pulse, LOAD_CYCLES=32 -> load_en high for exactly 32 cycles, then state=FETCH.
REQ-032 R-type op=6'h00 then halt_instr=1 -> FETCH, DECODE, EXEC, WB (reg_write=1, pc_en=1), FETCH, DECODE, HALT, with halted=1.
REQ-033 beq op=6'h04 with zero=1 -> pc_en=1 and pc_sel=1 in EXEC, next state FETCH; with zero=0 -> pc_sel=0.
REQ-034 lw op=6'h23 with dmem_ready after 3 cycles -> dmem_req high for 4 cycles, dmem_we=0, then WB with reg_write=1; sw 6'h2B -> dmem_we=1 and no WB.
REQ-035 MEM_TIMEOUT=15 with dmem_ready held low -> HALT after 15 MEM cycles with timeout_err=1; a subsequent start -> timeout_err=0 and state LOAD.
REQ-036 rst_n=0 asserted mid-MEM -> next cycle state=0 with all outputs 0; with MULTICYCLE_SEQ_PERF_EN defined, retired=0.
